uart_serial_rx: RTL
===================

UART_SERIAL_RX -- requirements
Module: uart_serial_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, meaning the CLOCK frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning the serial bit rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries; the value SHALL be a power of 2 and at least 2.
REQ-004 SHALL have port CLOCK  input  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port RESET_N  input  1  synchronous, active-low reset.
REQ-006 SHALL have port SRX  input  1  asynchronous serial line; idle high; framed as 8N1, LSB first.
REQ-007 SHALL have port RX_DATA  output  8  byte at the FIFO head.
REQ-008 SHALL have port RX_VALID  output  1  FIFO not empty.
REQ-009 SHALL have port RX_READY  input  1  consumer accepts RX_DATA when RX_VALID and RX_READY are both high.
REQ-010 SHALL have port FERR  output  1  one-cycle pulse on a framing error.
REQ-011 SHALL have port OVERRUN  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.

Function
REQ-012 SHALL pass SRX through a 2-flop synchronizer; both flops reset to 1.
REQ-013 SHALL generate a tick every DIV = CLK_FREQ/(BAUD_RATE*16) cycles (integer division, DIV >= 1); the divider SHALL reset to 0 in IDLE.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP and WAIT_HIGH; reset state is IDLE.
REQ-015 IDLE->START SHALL occur on the first synchronized SRX 1->0 transition.
REQ-016 START SHALL re-sample the line at tick 8: if 0, go to DATA; if 1, treat as a false start and return to IDLE with no output.
REQ-017 DATA SHALL sample every 16 ticks after the START mid-point, 8 bits, LSB first into bit 0, using a 3-bit bit counter.
REQ-018 STOP SHALL sample the line 16 ticks after the last data bit: if 1, push the byte and go to IDLE; if 0, pulse FERR, discard the byte and go to WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL stay there while the line is 0 and go to IDLE on the first 1, so a break never produces bytes.
REQ-020 Push latency SHALL be: RX_VALID high on the cycle after the stop-bit sample when the FIFO was empty.
REQ-021 The FIFO SHALL be first-word-fall-through; a pop occurs on RX_VALID & RX_READY.
REQ-022 A push while full SHALL drop the byte and pulse OVERRUN; FIFO contents are unchanged.
REQ-023 A push and pop in the same cycle while full SHALL be accepted as both, with no OVERRUN.
REQ-024 A push and pop in the same cycle while empty SHALL only push, and RX_VALID rises the next cycle.
REQ-025 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full and empty are decoded from the MSB difference.
REQ-026 RX_DATA SHALL be undefined-but-stable while RX_VALID=0; the consumer must not use it.

Reset
REQ-027 With RESET_N=0 at a CLOCK edge, the block SHALL go to: FSM IDLE, counters 0, FIFO empty, RX_VALID=0, RX_DATA=0, FERR=0, OVERRUN=0, synchronizer flops=1.
REQ-028 A reset mid-frame SHALL abandon the partial byte; reception restarts at the next falling edge after reset release.

Configuration
REQ-029 Macro UART_RX_PARITY_EN SHALL control even-parity checking.
REQ-030 With UART_RX_PARITY_EN defined, the FSM SHALL add state PARITY between DATA and STOP and sample one even-parity bit. A mismatch SHALL pulse output PERR for one cycle and discard the byte, while still checking the stop bit. PERR SHALL reset to 0.
REQ-031 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, the PARITY state and PERR port SHALL be absent, and the logic SHALL be identical to REQ-014..019.

Structure
REQ-032 A shared package uart_pkg SHALL hold the FSM state encoding, OVERSAMPLE=16 and the mid-point constant 8.
REQ-033 Sub-module uart_rx_fifo SHALL hold the FIFO (parameter FIFO_DEPTH, width 8), instantiated once.

Verification (CLK_FREQ=18432000, BAUD_RATE=115200, so DIV=10 and one bit = 160 cycles)
REQ-034 Drive 0x55 as 8N1 with RX_READY=1: RX_VALID SHALL rise with RX_DATA=0x55 one cycle after the stop-bit sample, and FERR=0.
REQ-035 Drive a low glitch of 50 cycles (shorter than 8 ticks): there SHALL be no RX_VALID, the FSM SHALL return to IDLE, then 0x3C sent next SHALL be received correctly.
REQ-036 Drive 0xA5 with stop bit 0, then hold the line low for 2 frames: there SHALL be one FERR pulse and no push; 0x3C sent after the line goes high SHALL be received.
REQ-037 Drive 0x01..0x05 with RX_READY=0 and FIFO_DEPTH=4: one OVERRUN pulse SHALL occur on 0x05; pops SHALL return 0x01, 0x02, 0x03, 0x04, then RX_VALID=0.
REQ-038 Assert RESET_N=0 for 1 cycle during data bit 3 of 0xFF: outputs SHALL be at reset values; the next byte 0x81 SHALL be received with no stale data.
REQ-039 With UART_RX_PARITY_EN: drive 0x07 with parity bit 0: there SHALL be one PERR pulse and no push; 0x07 with parity bit 1 SHALL be received.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receiver slice:
//   - FSM state encoding (3-bit localparams)
//   - OVERSAMPLE : baud ticks per serial bit
//   - MID_TICK   : tick index at which the start bit is re-sampled
//   - even_parity: helper returning the even-parity bit of a byte
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
  localparam logic [2:0] ST_PARITY    = 3'd5;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through byte FIFO for the UART receiver.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset (pointers cleared, overrun 0)
//   push       : write push_data this cycle
//   push_data  : byte to write
//   pop        : consumer ready; a pop happens only when the FIFO is not empty
//   head_data  : byte at the head (0 while empty)
//   not_empty  : head_data holds a valid byte
//   overrun    : one-cycle pulse when a push was dropped because of full
// Pointers are log2(FIFO_DEPTH)+1 bits; the extra MSB distinguishes full
// from empty when the index bits match.
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       not_empty,
  output logic       overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [FIFO_DEPTH];
  logic        empty;
  logic        full;
  logic        do_pop;
  logic        do_push;
  logic        drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot in the same cycle, so a push while full is still
  // accepted when it coincides with a pop. A pop while empty is ignored.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      overrun <= drop;
    end
  end

  // Storage needs no reset: it is only observed through head_data while
  // the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign not_empty = !empty;

endmodule

// File: rtl/uart_serial_rx.sv
// ---------------------------------------------------------------------------
// uart_serial_rx
// 16x oversampling UART receiver (8N1, LSB first) with a byte FIFO.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit between
// the data bits and the stop bit, and the PERR output.
// Ports:
//   CLOCK     : rising-edge clock
//   RESET_N   : synchronous active-low reset
//   SRX       : asynchronous serial input, idle high
//   RX_DATA   : byte at the FIFO head (0 while RX_VALID=0)
//   RX_VALID  : FIFO not empty
//   RX_READY  : consumer ready
//   FERR      : one-cycle pulse on a framing error (stop bit 0)
//   OVERRUN   : one-cycle pulse when a byte is dropped on a full FIFO
//   PERR      : one-cycle pulse on a parity mismatch (parity build only)
//   FSM_STATE : current receiver state (debug observation)
// Handshake: a byte transfers on every rising edge where RX_VALID and
// RX_READY are both high; RX_DATA is held stable until that transfer, and
// RX_READY may be high while RX_VALID is low without effect.
// ---------------------------------------------------------------------------
module uart_serial_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       SRX,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       FERR,
  output logic       OVERRUN,
`ifdef UART_RX_PARITY_EN
  output logic       PERR,
`endif
  output logic [2:0] FSM_STATE
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [3:0] MID_LAST = 4'(MID_TICK - 1);
  localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);

  logic             sync1;
  logic             sync2;
  logic             prev;
  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             tick;
  logic             fall;
  logic             mid_pt;
  logic             bit_pt;
  logic             push;
`ifdef UART_RX_PARITY_EN
  logic             perr_flag;
`endif

  // The divider is held at 0 in IDLE so the first tick of a frame lands a
  // fixed DIV cycles after the detected falling edge.
  assign tick   = (state != ST_IDLE) && (div_cnt == DIV_LAST);
  assign fall   = prev & ~sync2;
  assign mid_pt = tick && (tick_cnt == MID_LAST);
  assign bit_pt = tick && (tick_cnt == BIT_LAST);

  // The byte is pushed on the stop-bit sample itself, so RX_VALID rises on
  // the following cycle when the FIFO was empty.
`ifdef UART_RX_PARITY_EN
  assign push = (state == ST_STOP) && bit_pt && sync2 && !perr_flag;
`else
  assign push = (state == ST_STOP) && bit_pt && sync2;
`endif

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      prev      <= 1'b1;
      state     <= ST_IDLE;
      div_cnt   <= '0;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      FERR      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PERR      <= 1'b0;
      perr_flag <= 1'b0;
`endif
    end else begin
      sync1 <= SRX;
      sync2 <= sync1;
      prev  <= sync2;
      FERR  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PERR  <= 1'b0;
`endif

      if (state == ST_IDLE || div_cnt == DIV_LAST) div_cnt <= '0;
      else div_cnt <= div_cnt + DIV_W'(1);

      // Free-running 4-bit tick counter; wrapping 15->0 marks each bit centre.
      if (tick) tick_cnt <= tick_cnt + 4'd1;

      case (state)
        ST_IDLE: begin
          tick_cnt <= 4'd0;
          bit_cnt  <= 3'd0;
`ifdef UART_RX_PARITY_EN
          perr_flag <= 1'b0;
`endif
          if (fall) state <= ST_START;
        end
        ST_START: begin
          if (mid_pt) begin
            tick_cnt <= 4'd0;
            state    <= sync2 ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_pt) begin
            shreg   <= {sync2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_pt) begin
            perr_flag <= (sync2 != even_parity(shreg));
            PERR      <= (sync2 != even_parity(shreg));
            state     <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_pt) begin
            if (sync2) begin
              state <= ST_IDLE;
            end else begin
              FERR  <= 1'b1;
              state <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          // A held-low line (break) parks here until it returns high.
          if (sync2) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign FSM_STATE = state;

  uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK),
    .rst_n     (RESET_N),
    .push      (push),
    .push_data (shreg),
    .pop       (RX_READY),
    .head_data (RX_DATA),
    .not_empty (RX_VALID),
    .overrun   (OVERRUN)
  );

endmodule
